gamma_lut_writer: RTL and testbench
===================================

Name: gamma_lut_writer

Overview:
- Generates the 256-entry 8-bit gamma curve tables and streams them, entry by entry, over a write port into a gamma RAM.
- Pipeline gamma stages read that RAM with the pixel value as the address.
- Runtime replacement for fixed sqrt/square ROM init files; curve is selected per fill.
- Sits in the control domain beside the demosaic pipeline and is triggered at configuration time or between frames.

Parameters:
- DW, 8, data/address width of one table entry; fixed at 8, with 2**DW = 256 entries.
- CURVE_W, 2, width of curve_sel.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle pulse; begins a table fill; ignored unless in IDLE
- curve_sel  in  2  0 = identity, 1 = sqrt (brighten), 2 = square (darken), 3 = reserved (treated as identity); sampled on accepted start
- wr_valid  out  1  write entry presented
- wr_ready  in  1  RAM accepts entry; transfer occurs when wr_valid & wr_ready
- wr_addr  out  8  table address
- wr_data  out  8  table value
- busy  out  1  high from the cycle after an accepted start until the last transfer
- done  out  1  one-cycle pulse the cycle after the last transfer (addr 255)

Behaviour:
- Reset: state = IDLE; wr_valid = 0, wr_addr = 0, wr_data = 0, busy = 0, done = 0; address counter = 0. Reset mid-fill aborts immediately and issues no further writes. A partially written RAM is the system's concern.
- FSM states: IDLE, CALC, WRITE, DONE.
- IDLE:
  - start = 1 latches curve_sel, clears the counter to 0, and goes to CALC.
  - busy rises the next cycle.
- CALC: computes f(addr) for the current counter value.
  - sqrt: f(x) = floor(sqrt(255*x)). Uses a 16-bit radicand and a restoring bit-serial square root, one result bit per cycle, MSB first: exactly 8 cycles in CALC.
  - square: f(x) = floor((x*x + 127) / 255), i.e. x²/255 rounded to nearest. Uses a 16-bit product and a 17-bit intermediate; no true divider. Exactly 1 cycle in CALC.
  - identity/reserved: f(x) = x. 1 cycle in CALC.
  - The result is registered into wr_data, wr_addr = counter, and the FSM goes to WRITE.
- WRITE:
  - wr_valid = 1; wr_addr and wr_data stay stable until the transfer.
  - On wr_valid & wr_ready: wr_valid drops the next cycle.
  - If counter = 255, go to DONE. Otherwise increment the counter and go to CALC.
  - wr_ready low holds WRITE indefinitely with outputs unchanged.
- DONE: done = 1 for exactly one cycle, busy = 0, then IDLE.
- Timing with wr_ready held high (start in cycle 0):
  - sqrt: 256*(8+1) = 2304 cycles of busy; done in cycle 2305.
  - square/identity: 256*2 = 512 cycles of busy; done in cycle 513.
- Boundaries and side conditions:
  - f(0) = 0 and f(255) = 255 for all curves; no saturation logic is needed, and all results fit in 8 bits.
  - The counter never wraps: the addr 255 transfer ends the fill.
  - start while busy or in DONE is ignored, and so is a curve_sel change mid-fill.
  - start in the same cycle as rst: reset wins.
  - wr_ready is ignored while wr_valid = 0.

Optional Feature:
- Macro: GAMMA_LUT_CHECKSUM_EN.
- Defined:
  - Adds output port checksum (16 bits), a running modulo-2^16 sum of wr_data over accepted transfers.
  - Cleared to 0 on reset and on accepted start; held after done until the next start.
- Undefined: no port and no logic.
- All other behaviour is identical in both builds.

Test Plan:
- Identity fill, wr_ready = 1: start with curve_sel = 0 -> 256 transfers with wr_data == wr_addr; done exactly 513 cycles after start; checksum (if enabled) = 0x7F80.
- Sqrt fill: curve_sel = 1 -> addr 0 gives 0, 1 gives 15, 64 gives 127, 128 gives 180, 255 gives 255; busy high for 2304 cycles.
- Square fill: curve_sel = 2 -> addr 8 gives 0, 16 gives 1, 128 gives 64, 200 gives 157, 255 gives 255.
- Backpressure: wr_ready random at 50%, held low 20 cycles at addr 100 -> wr_addr/wr_data stable while stalled; no duplicated or skipped addresses; done once.
- Start ignored: second start pulse at addr 50 with curve_sel changed -> fill continues with the original curve; exactly 256 transfers.
- Reset mid-fill: rst at addr 30 -> next cycle wr_valid = 0, busy = 0, done never pulses; a subsequent start refills from addr 0.

Source files
------------

// File: rtl/gamma_lut_writer.sv
`default_nettype none
// ============================================================================
// Module      : gamma_lut_writer
// Description : Computes a 256-entry 8-bit gamma table (identity, sqrt or
//               square curve) one entry at a time and streams each entry
//               over a valid/ready write port into the gamma RAM.
//               Optional build macro GAMMA_LUT_CHECKSUM_EN adds a 16-bit
//               running checksum of the accepted write data.
// Revision    : 1.0 - initial release
// ============================================================================
module gamma_lut_writer #(
    parameter int DW      = 8,
    parameter int CURVE_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CURVE_W-1:0] curve_sel,
    output logic               wr_valid,
    input  logic               wr_ready,
    output logic [DW-1:0]      wr_addr,
    output logic [DW-1:0]      wr_data,
    output logic               busy,
    output logic               done
`ifdef GAMMA_LUT_CHECKSUM_EN
    ,
    output logic [15:0]        checksum
`endif
);

    // FSM encoding
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_CALC  = 2'd1;
    localparam logic [1:0] c_WRITE = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    // Curve codes; anything else (including the reserved code) is identity
    localparam logic [CURVE_W-1:0] c_SQRT   = CURVE_W'(1);
    localparam logic [CURVE_W-1:0] c_SQUARE = CURVE_W'(2);

    localparam logic [DW-1:0] c_LAST_ADDR = {DW{1'b1}};

    logic [1:0]         r_state;
    logic [CURVE_W-1:0] r_curve;
    logic [DW-1:0]      r_cnt;
    logic [DW-1:0]      r_addr;
    logic [DW-1:0]      r_data;
    logic               r_valid;
    logic               r_busy;
    logic               r_done;

    // Bit-serial square root state: partial root, partial remainder, step
    logic [7:0]         r_root;
    logic [9:0]         r_rem;
    logic [2:0]         r_step;

`ifdef GAMMA_LUT_CHECKSUM_EN
    logic [15:0]        r_checksum;
`endif

    // ------------------------------------------------------------------
    // Square root datapath: radicand = 255*x, consumed two bits per step
    // MSB pair first. Each step shifts in a pair, tries to subtract
    // 4*root+1, and appends the resulting root bit.
    // ------------------------------------------------------------------
    logic [15:0] w_rad;
    logic [2:0]  w_pair_idx;
    logic [1:0]  w_pair;
    logic [11:0] w_rem_shift;
    logic [11:0] w_trial;
    logic        w_ge;
    logic [9:0]  w_rem_next;
    logic [7:0]  w_root_next;

    assign w_rad       = {r_cnt, 8'h00} - {8'h00, r_cnt};
    assign w_pair_idx  = 3'd7 - r_step;
    assign w_pair      = w_rad[{w_pair_idx, 1'b1} -: 2];
    assign w_rem_shift = {r_rem, w_pair};
    assign w_trial     = {2'b00, r_root, 2'b01};
    assign w_ge        = (w_rem_shift >= w_trial);
    // The true remainder never exceeds 2*root (< 1024), so 10 bits suffice
    assign w_rem_next  = w_ge ? (w_rem_shift[9:0] - w_trial[9:0]) : w_rem_shift[9:0];
    assign w_root_next = {r_root[6:0], w_ge};

    // ------------------------------------------------------------------
    // Square datapath: floor((x*x + 127) / 255) without a divider.
    // For n < 65535, floor(n/255) == (n + 1 + (n >> 8)) >> 8.
    // ------------------------------------------------------------------
    logic [15:0] w_sq;
    logic [16:0] w_num;
    logic [16:0] w_quot;
    logic [7:0]  w_sq_res;
    logic        w_unused_sq;

    assign w_sq        = {8'h00, r_cnt} * {8'h00, r_cnt};
    assign w_num       = {1'b0, w_sq} + 17'd127;
    assign w_quot      = w_num + 17'd1 + {8'h00, w_num[16:8]};
    assign w_sq_res    = w_quot[15:8];
    assign w_unused_sq = ^{w_quot[16], w_quot[7:0]};

    // Control FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_curve <= '0;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_root  <= '0;
            r_rem   <= '0;
            r_step  <= '0;
`ifdef GAMMA_LUT_CHECKSUM_EN
            r_checksum <= '0;
`endif
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_curve <= curve_sel;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_root  <= '0;
                        r_rem   <= '0;
                        r_step  <= '0;
`ifdef GAMMA_LUT_CHECKSUM_EN
                        r_checksum <= '0;
`endif
                        r_state <= c_CALC;
                    end
                end

                c_CALC: begin
                    if (r_curve == c_SQRT) begin
                        // One root bit per cycle; eighth step yields the entry
                        r_root <= w_root_next;
                        r_rem  <= w_rem_next;
                        r_step <= r_step + 3'd1;
                        if (r_step == 3'd7) begin
                            r_data  <= w_root_next;
                            r_addr  <= r_cnt;
                            r_valid <= 1'b1;
                            r_state <= c_WRITE;
                        end
                    end else begin
                        r_data  <= (r_curve == c_SQUARE) ? w_sq_res : r_cnt;
                        r_addr  <= r_cnt;
                        r_valid <= 1'b1;
                        r_state <= c_WRITE;
                    end
                end

                c_WRITE: begin
                    // Address/data stay put until the RAM takes the entry
                    if (r_valid && wr_ready) begin
                        r_valid <= 1'b0;
`ifdef GAMMA_LUT_CHECKSUM_EN
                        r_checksum <= r_checksum + {8'h00, r_data};
`endif
                        if (r_cnt == c_LAST_ADDR) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= c_DONE;
                        end else begin
                            r_cnt   <= r_cnt + 1'b1;
                            r_root  <= '0;
                            r_rem   <= '0;
                            r_step  <= '0;
                            r_state <= c_CALC;
                        end
                    end
                end

                c_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= c_IDLE;
                end

                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign wr_valid = r_valid;
    assign wr_addr  = r_addr;
    assign wr_data  = r_data;
    assign busy     = r_busy;
    assign done     = r_done;
`ifdef GAMMA_LUT_CHECKSUM_EN
    assign checksum = r_checksum;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gamma_lut_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_gamma_lut_writer
// Description : Directed self-checking bench for gamma_lut_writer: reset
//               state, identity/sqrt/square fills, backpressure, ignored
//               start, and reset mid-fill.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gamma_lut_writer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] curve_sel;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       done;
`ifdef GAMMA_LUT_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    always #5 clk = ~clk;

    gamma_lut_writer #(.DW(8), .CURVE_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .curve_sel (curve_sel),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done)
`ifdef GAMMA_LUT_CHECKSUM_EN
        ,
        .checksum  (checksum)
`endif
    );

    int checks = 0;
    int errors = 0;

    int         exp_curve = 0;
    int         exp_next  = 0;
    int         xfer_cnt  = 0;
    int         done_cnt  = 0;
    int         busy_cnt  = 0;
    int         sum       = 0;
    logic [7:0] data_log [256];
    bit         prev_stall = 1'b0;
    logic [7:0] prev_addr;
    logic [7:0] prev_data;
    int         cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference curves via linear search and true division
    function automatic logic [7:0] model(input int c, input logic [7:0] x);
        int xi;
        int r;
        xi = int'(x);
        if (c == 1) begin
            r = 0;
            while ((r + 1) * (r + 1) <= 255 * xi) r++;
            return 8'(r);
        end else if (c == 2) begin
            return 8'((xi * xi + 127) / 255);
        end
        return x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transfer monitor: ordering, values, stall stability, pulse counts
    always @(negedge clk) begin
        if (prev_stall) begin
            chk("stall_valid", {31'b0, wr_valid}, 32'd1);
            chk("stall_addr", {24'b0, wr_addr}, {24'b0, prev_addr});
            chk("stall_data", {24'b0, wr_data}, {24'b0, prev_data});
        end
        prev_stall = (rst === 1'b0) && (wr_valid === 1'b1) && (wr_ready === 1'b0);
        prev_addr  = wr_addr;
        prev_data  = wr_data;
        if (rst === 1'b0 && wr_valid === 1'b1 && wr_ready === 1'b1) begin
            chk("addr_seq", {24'b0, wr_addr}, exp_next);
            chk("entry_data", {24'b0, wr_data}, {24'b0, model(exp_curve, wr_addr)});
            data_log[wr_addr] = wr_data;
            exp_next = int'(wr_addr) + 1;
            xfer_cnt++;
            sum += int'(wr_data);
        end
        if (done === 1'b1) done_cnt++;
        if (busy === 1'b1) busy_cnt++;
    end

    // mode 0: plain, 1: random backpressure + 20-cycle stall at addr 100,
    // 2: extra start with changed curve at addr 50, 3: reset at addr 30
    task automatic fill(input logic [1:0] c, input int mode, input int limit, output int cycles);
        bit         fired;
        logic [7:0] trig;
        fired = (mode == 0);
        trig  = (mode == 1) ? 8'd100 : (mode == 2) ? 8'd50 : 8'd30;
        exp_curve = (c == 2'd3) ? 0 : int'(c);
        exp_next  = 0;
        xfer_cnt  = 0;
        done_cnt  = 0;
        busy_cnt  = 0;
        sum       = 0;
        for (int i = 0; i < 256; i++) data_log[i] = 8'hxx;
        curve_sel = c;
        wr_ready  = (mode != 1);
        start     = 1'b1;
        tick();
        start  = 1'b0;
        cycles = 1;
        while (done !== 1'b1 && cycles < limit) begin
            start = 1'b0;
            if (!fired && wr_valid === 1'b1 && wr_addr === trig) begin
                fired = 1'b1;
                if (mode == 1) begin
                    wr_ready = 1'b0;
                    repeat (20) tick();
                    cycles += 20;
                end else if (mode == 2) begin
                    start     = 1'b1;
                    curve_sel = c ^ 2'b11;
                end else begin
                    rst = 1'b1;
                    tick();
                    rst = 1'b0;
                    chk("rst_mid_valid", {31'b0, wr_valid}, 32'd0);
                    chk("rst_mid_busy", {31'b0, busy}, 32'd0);
                    repeat (30) tick();
                    chk("rst_mid_no_done", done_cnt, 32'd0);
                    chk("rst_mid_xfers", xfer_cnt, 32'd30);
                    chk("rst_mid_idle_valid", {31'b0, wr_valid}, 32'd0);
                    break;
                end
            end
            if (mode == 1) wr_ready = 1'($urandom_range(0, 1));
            tick();
            cycles++;
        end
        start = 1'b0;
    endtask

    // Post-fill checks: done seen, timing, single pulse, transfer count
    task automatic post(input string tag, input int exp_cyc, input int cycles, input int exp_busy);
        chk({tag, "_done_seen"}, {31'b0, done}, 32'd1);
        if (exp_cyc > 0) chk({tag, "_done_cycle"}, cycles, exp_cyc);
        tick();
        chk({tag, "_done_fall"}, {31'b0, done}, 32'd0);
        chk({tag, "_busy_fall"}, {31'b0, busy}, 32'd0);
        repeat (3) tick();
        chk({tag, "_done_once"}, done_cnt, 32'd1);
        chk({tag, "_xfers"}, xfer_cnt, 32'd256);
        if (exp_busy > 0) chk({tag, "_busy_cycles"}, busy_cnt, exp_busy);
`ifdef GAMMA_LUT_CHECKSUM_EN
        chk({tag, "_checksum"}, {16'b0, checksum}, {16'b0, sum[15:0]});
`endif
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        curve_sel = 2'd0;
        wr_ready  = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset_valid", {31'b0, wr_valid}, 32'd0);
        chk("reset_addr", {24'b0, wr_addr}, 32'd0);
        chk("reset_data", {24'b0, wr_data}, 32'd0);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);

        // start coincident with reset: reset wins
        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        chk("rst_start_busy", {31'b0, busy}, 32'd0);
        tick();
        chk("rst_start_busy_late", {31'b0, busy}, 32'd0);
        chk("rst_start_valid", {31'b0, wr_valid}, 32'd0);

        // identity fill
        fill(2'd0, 0, 600, cyc);
        post("ident", 513, cyc, 512);
        chk("ident_a0", {24'b0, data_log[0]}, 32'd0);
        chk("ident_a77", {24'b0, data_log[77]}, 32'd77);
`ifdef GAMMA_LUT_CHECKSUM_EN
        chk("ident_checksum_const", {16'b0, checksum}, 32'h7F80);
`endif

        // sqrt fill
        fill(2'd1, 0, 2400, cyc);
        post("sqrt", 2305, cyc, 2304);
        chk("sqrt_a0", {24'b0, data_log[0]}, 32'd0);
        chk("sqrt_a1", {24'b0, data_log[1]}, 32'd15);
        chk("sqrt_a64", {24'b0, data_log[64]}, 32'd127);
        chk("sqrt_a128", {24'b0, data_log[128]}, 32'd180);
        chk("sqrt_a255", {24'b0, data_log[255]}, 32'd255);

        // square fill with an ignored start (curve changed) at addr 50
        fill(2'd2, 2, 600, cyc);
        post("square", 513, cyc, 512);
        chk("sq_a8", {24'b0, data_log[8]}, 32'd0);
        chk("sq_a16", {24'b0, data_log[16]}, 32'd1);
        chk("sq_a100", {24'b0, data_log[100]}, 32'd39);
        chk("sq_a128", {24'b0, data_log[128]}, 32'd64);
        chk("sq_a200", {24'b0, data_log[200]}, 32'd157);
        chk("sq_a255", {24'b0, data_log[255]}, 32'd255);

        // reserved curve under random backpressure
        fill(2'd3, 1, 5000, cyc);
        post("bp", -1, cyc, -1);
        chk("bp_a100", {24'b0, data_log[100]}, 32'd100);
        chk("bp_a255", {24'b0, data_log[255]}, 32'd255);

        // reset mid-fill, then a clean refill from addr 0
        fill(2'd0, 3, 600, cyc);
        fill(2'd0, 0, 600, cyc);
        post("refill", 513, cyc, 512);
        chk("refill_a0", {24'b0, data_log[0]}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
